// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one down-counter between two requesters.
// state | meaning: IDLE wait for req | LOAD load terminal count | RUN count down | DONE pulse done
module timer_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  input  logic             cancel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, busy_nxt;
  logic             ptr, ptr_nxt;
  logic             abort;

  assign abort = (state != IDLE) &&
                 (cancel || (gnt0 && !req0) || (gnt1 && !req1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      gnt0  <= gnt0_nxt;
      gnt1  <= gnt1_nxt;
      done0 <= done0_nxt;
      done1 <= done1_nxt;
      busy  <= busy_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    gnt0_nxt  = gnt0;
    gnt1_nxt  = gnt1;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
    ptr_nxt   = ptr;
    // Abort still rotates the pointer so a flapping requester cannot starve its peer
    if (abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
      gnt0_nxt  = 1'b0;
      gnt1_nxt  = 1'b0;
      ptr_nxt   = gnt0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || !ptr)) begin
            gnt0_nxt  = 1'b1;
            state_nxt = LOAD;
          end else if (req1) begin
            gnt1_nxt  = 1'b1;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          count_nxt = gnt1 ? val1 : val0;
          state_nxt = RUN;
        end
        RUN: begin
          if (count == '0) begin
            done0_nxt = gnt0;
            done1_nxt = gnt1;
            state_nxt = DONE;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
        DONE: begin
          state_nxt = IDLE;
          count_nxt = '0;
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
          ptr_nxt   = gnt0;
        end
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter; outputs sampled 1 time unit after each rising edge.
module tb_timer_arbiter;

  logic       clk, rst, req0, req1, cancel;
  logic [7:0] val0, val1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] count;
  int         checks = 0;
  int         errors = 0;

  timer_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .val0(val0), .val1(val1),
    .cancel(cancel), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .count(count), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    chk1("inv_busy", busy, gnt0 | gnt1);
    chk1("inv_onehot", gnt0 & gnt1, 1'b0);
    chk1("inv_done0_gnt0", done0 & ~gnt0, 1'b0);
    chk1("inv_done1_gnt1", done1 & ~gnt1, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cancel = 1'b0; val0 = '0; val1 = '0;
    @(posedge clk);
    #1;
    chk8("rst_count", count, 8'd0);
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done0", done0, 1'b0);
    rst = 1'b0;

    // single request, val0=5
    req0 = 1'b1; val0 = 8'd5;
    tick;
    chk1("single_gnt0_e0", gnt0, 1'b1);
    chk1("single_busy_e0", busy, 1'b1);
    chk8("single_cnt_e0", count, 8'd0);
    tick;
    chk8("single_cnt_e1", count, 8'd5);
    for (int i = 4; i >= 0; i--) begin
      tick;
      chk8("single_cnt_run", count, 8'(i));
      chk1("single_done0_run", done0, 1'b0);
    end
    tick;
    chk1("single_done0_e7", done0, 1'b1);
    chk1("single_gnt0_e7", gnt0, 1'b1);
    chk1("single_done1_e7", done1, 1'b0);
    chk1("single_gnt1_e7", gnt1, 1'b0);
    tick;
    chk1("single_gnt0_e8", gnt0, 1'b0);
    chk1("single_done0_e8", done0, 1'b0);
    chk1("single_busy_e8", busy, 1'b0);
    req0 = 1'b0;

    // async reset mid-run; pointer currently favours requester 1
    req0 = 1'b1; val0 = 8'd255;
    tick;
    chk1("areset_gnt0_e0", gnt0, 1'b1);
    tick;
    chk8("areset_cnt_e1", count, 8'd255);
    tick;
    chk8("areset_cnt_e2", count, 8'd254);
    #3;
    rst = 1'b1;
    #1;
    chk1("areset_gnt0_now", gnt0, 1'b0);
    chk1("areset_busy_now", busy, 1'b0);
    chk8("areset_cnt_now", count, 8'd0);
    chk1("areset_done0_now", done0, 1'b0);
    req1 = 1'b1;
    @(posedge clk);
    #1;
    chk1("areset_gnt0_held", gnt0, 1'b0);
    rst = 1'b0;
    tick;
    chk1("areset_gnt0_after", gnt0, 1'b1);
    chk1("areset_gnt1_after", gnt1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    do_reset;

    // contention: val0=2, val1=3
    req0 = 1'b1; req1 = 1'b1; val0 = 8'd2; val1 = 8'd3;
    tick;
    chk1("cont_gnt0_e0", gnt0, 1'b1);
    chk1("cont_gnt1_e0", gnt1, 1'b0);
    tick;
    chk8("cont_cnt_e1", count, 8'd2);
    tick;
    tick;
    chk8("cont_cnt_e3", count, 8'd0);
    tick;
    chk1("cont_done0_e4", done0, 1'b1);
    chk1("cont_done1_e4", done1, 1'b0);
    tick;
    chk1("cont_gnt0_e5", gnt0, 1'b0);
    chk1("cont_busy_e5", busy, 1'b0);
    tick;
    chk1("cont_gnt1_e6", gnt1, 1'b1);
    chk1("cont_gnt0_e6", gnt0, 1'b0);
    tick;
    chk8("cont_cnt_e7", count, 8'd3);
    for (int i = 2; i >= 0; i--) begin
      tick;
      chk8("cont_cnt_run1", count, 8'(i));
    end
    tick;
    chk1("cont_done1_e11", done1, 1'b1);
    chk1("cont_done0_e11", done0, 1'b0);
    tick;
    chk1("cont_gnt1_e12", gnt1, 1'b0);
    chk1("cont_busy_e12", busy, 1'b0);
    tick;
    chk1("cont_gnt0_e13", gnt0, 1'b1);
    chk1("cont_gnt1_e13", gnt1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    chk1("cont_abandon_gnt0", gnt0, 1'b0);
    chk1("cont_abandon_done0", done0, 1'b0);

    // zero count on requester 1
    req1 = 1'b1; val1 = 8'd0;
    tick;
    chk1("zero_gnt1_e0", gnt1, 1'b1);
    tick;
    chk1("zero_gnt1_e1", gnt1, 1'b1);
    chk8("zero_cnt_e1", count, 8'd0);
    chk1("zero_done1_e1", done1, 1'b0);
    tick;
    chk1("zero_done1_e2", done1, 1'b1);
    chk1("zero_gnt1_e2", gnt1, 1'b1);
    tick;
    chk1("zero_gnt1_e3", gnt1, 1'b0);
    chk1("zero_done1_e3", done1, 1'b0);
    req1 = 1'b0;

    // cancel mid-run, then pending req1 and cancel coincident with zero
    req0 = 1'b1; req1 = 1'b1; val0 = 8'd10; val1 = 8'd0;
    tick;
    chk1("cancel_gnt0_e0", gnt0, 1'b1);
    tick;
    chk8("cancel_cnt_e1", count, 8'd10);
    for (int i = 9; i >= 6; i--) begin
      tick;
      chk8("cancel_cnt_run", count, 8'(i));
    end
    cancel = 1'b1;
    tick;
    chk1("cancel_gnt0_ea", gnt0, 1'b0);
    chk1("cancel_busy_ea", busy, 1'b0);
    chk8("cancel_cnt_ea", count, 8'd0);
    chk1("cancel_done0_ea", done0, 1'b0);
    chk1("cancel_gnt1_ea", gnt1, 1'b0);
    cancel = 1'b0; req0 = 1'b0;
    tick;
    chk1("cancel_gnt1_ea1", gnt1, 1'b1);
    tick;
    chk8("czero_cnt_run", count, 8'd0);
    cancel = 1'b1;
    tick;
    chk1("czero_done1", done1, 1'b0);
    chk1("czero_gnt1", gnt1, 1'b0);
    chk1("czero_busy", busy, 1'b0);
    cancel = 1'b0; req1 = 1'b0;
    tick;
    chk1("czero_idle_busy", busy, 1'b0);
    chk1("czero_idle_done1", done1, 1'b0);

    // cancel in IDLE does not block a grant; abort then follows in LOAD
    cancel = 1'b1; req0 = 1'b1; val0 = 8'd3;
    tick;
    chk1("idlecan_gnt0", gnt0, 1'b1);
    tick;
    chk1("idlecan_abort_gnt0", gnt0, 1'b0);
    chk8("idlecan_abort_cnt", count, 8'd0);
    cancel = 1'b0; req0 = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
